// File: rtl/cvp14_mem_responder.sv
// CVP14 memory responder: posted write buffer drained into a single-port synchronous array,
// reads forwarded from the buffer when it holds a newer copy, returned through RD_LATENCY stages.
module cvp14_mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 2,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              RdValid,
  output logic              Busy,
  output logic              Idle,
  output logic              Ovf
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] idx;
  assign idx = Addr[IDX_W-1:0];

  // Upper address bits alias onto the array; they are intentionally ignored.
  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^Addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  logic [IDX_W-1:0]  wb_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;
  logic              ovf_q, ovf_d;
  logic              full, push, drain;

  assign full  = (cnt_q == CNT_W'(WBUF_DEPTH));
  assign push  = WR && !full;
  // Reads own the array port, so draining waits for a cycle without RD.
  assign drain = !RD && (cnt_q != '0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (WR & full);
    if (push)  tail_d = tail_q + 1'b1;
    if (drain) head_d = head_q + 1'b1;
    case ({push, drain})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d == CNT_W'(WBUF_DEPTH));
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge Clk1) begin
    if (push && !Reset) begin
      wb_addr_q[tail_q] <= idx;
      wb_data_q[tail_q] <= DataIn;
    end
  end

  // Walk oldest to youngest so the last match seen is the newest copy.
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_dat;
  logic [PTR_W-1:0]  slot;

  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    slot    = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < cnt_q) && (wb_addr_q[slot] == idx)) begin
        fwd_hit = 1'b1;
        fwd_dat = wb_data_q[slot];
      end
    end
  end

  // Backing array is never reset; pending writes are discarded on Reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk1) begin
    if (drain && !Reset) begin
      mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
    end
  end

  logic [DATA_W-1:0]     pdat_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] pvld_q;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      pvld_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) pdat_q[s] <= '0;
    end else begin
      pvld_q[0] <= RD;
      if (RD) pdat_q[0] <= fwd_hit ? fwd_dat : mem_q[idx];
      // Stages load only behind a valid beat so DataOut holds between reads.
      for (int s = 1; s < RD_LATENCY; s++) begin
        pvld_q[s] <= pvld_q[s-1];
        if (pvld_q[s-1]) pdat_q[s] <= pdat_q[s-1];
      end
    end
  end

  assign DataOut = pdat_q[RD_LATENCY-1];
  assign RdValid = pvld_q[RD_LATENCY-1];
  assign Busy    = busy_q;
  assign Ovf     = ovf_q;
  assign Idle    = (cnt_q == '0) && !(|pvld_q);

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Bench for cvp14_mem_responder: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cvp14_mem_responder;
  localparam int N   = 2;
  localparam int WBD = 4;

  logic        Clk1 = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Addr = '0;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [15:0] DataIn = '0;
  logic [15:0] DataOut;
  logic        RdValid, Busy, Idle, Ovf;

  cvp14_mem_responder dut (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
    .DataOut(DataOut), .RdValid(RdValid), .Busy(Busy), .Idle(Idle), .Ovf(Ovf)
  );

  always #5 Clk1 = ~Clk1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffer as a FIFO queue, reads as a queue of (due edge, data).
  typedef struct { logic [9:0] a; logic [15:0] d; } wr_t;
  typedef struct { int due; logic [15:0] d; } rd_t;
  wr_t         wq[$];
  rd_t         rq[$];
  logic [15:0] mm [1024];
  int          edge_n = 0;
  bit          chk_en = 1'b0;
  logic [15:0] e_dat;
  logic        e_vld, e_busy, e_idle, e_ovf;

  always @(posedge Clk1) begin
    wr_t w;
    rd_t r;
    logic [15:0] v;
    bit pok;
    edge_n++;
    if (Reset) begin
      wq.delete();
      rq.delete();
      e_dat = '0; e_vld = 1'b0; e_busy = 1'b0; e_idle = 1'b1; e_ovf = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (RD) begin
        v = mm[Addr[9:0]];
        foreach (wq[i]) if (wq[i].a == Addr[9:0]) v = wq[i].d;
        r.due = edge_n + N - 1;
        r.d = v;
        rq.push_back(r);
      end
      pok = WR && (wq.size() < WBD);
      if (WR && !pok) e_ovf = 1'b1;
      if (!RD && wq.size() > 0) begin
        w = wq.pop_front();
        mm[w.a] = w.d;
      end
      if (pok) begin
        w.a = Addr[9:0];
        w.d = DataIn;
        wq.push_back(w);
      end
      e_busy = (wq.size() == WBD);
      e_idle = (wq.size() == 0) && (rq.size() == 0);
      e_vld = 1'b0;
      if (rq.size() > 0 && rq[0].due == edge_n) begin
        r = rq.pop_front();
        e_vld = 1'b1;
        e_dat = r.d;
      end
    end
  end

  always @(negedge Clk1) begin
    if (chk_en) begin
      chk("m_RdValid", RdValid, e_vld);
      chk("m_DataOut", DataOut, e_dat);
      chk("m_Busy", Busy, e_busy);
      chk("m_Idle", Idle, e_idle);
      chk("m_Ovf", Ovf, e_ovf);
    end
  end

  task automatic step(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    RD = rd; WR = wr; Addr = a; DataIn = d;
    @(posedge Clk1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] exp5 [5];

    // T1 reset
    Reset = 1'b1;
    idle(2);
    chk("t1_DataOut", DataOut, 16'h0);
    chk("t1_RdValid", RdValid, 1'b0);
    chk("t1_Busy", Busy, 1'b0);
    chk("t1_Idle", Idle, 1'b1);
    chk("t1_Ovf", Ovf, 1'b0);
    Reset = 1'b0;

    // T2 write then forwarded read
    step(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    chk("t2_not_early", RdValid, 1'b0);
    idle(1);
    chk("t2_RdValid", RdValid, 1'b1);
    chk("t2_DataOut", DataOut, 16'hBEEF);
    idle(3);

    // T3 drain to array and read back to back
    for (int a = 0; a < 4; a++) step(1'b0, 1'b1, 16'(a), 16'h1000 + 16'(a));
    idle(4);
    chk("t3_Idle", Idle, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 16'(k), 16'h0);
      if (k >= 1) begin
        chk("t3_vld", RdValid, 1'b1);
        chk("t3_dat", DataOut, 16'h1000 + 16'(k - 1));
      end
    end
    idle(1);
    chk("t3_dat_last", DataOut, 16'h1003);
    idle(1);
    chk("t3_vld_off", RdValid, 1'b0);
    chk("t3_hold", DataOut, 16'h1003);

    // Preload words used by the later scenarios
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0040 + 16'(i), 16'hA000 + 16'(i));
    step(1'b0, 1'b1, 16'h0020, 16'h1111);
    step(1'b0, 1'b1, 16'h0050, 16'hC050);
    step(1'b0, 1'b1, 16'h0051, 16'hC051);
    idle(4);

    // T4 overflow while reads hold the port
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 16'h0040 + 16'(i), 16'hB000 + 16'(i));
      if (i == 1) chk("t4_old_data", DataOut, 16'hA000);
      if (i == 2) chk("t4_not_busy", Busy, 1'b0);
      if (i == 3) chk("t4_busy", Busy, 1'b1);
      if (i == 4) chk("t4_ovf", Ovf, 1'b1);
    end
    idle(6);
    exp5[0] = 16'hB000; exp5[1] = 16'hB001; exp5[2] = 16'hB002;
    exp5[3] = 16'hB003; exp5[4] = 16'hA004;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 16'h0040 + 16'(k), 16'h0);
      if (k >= 1) chk("t4_readback", DataOut, exp5[k-1]);
    end
    idle(1);
    chk("t4_readback_last", DataOut, exp5[4]);
    idle(2);

    // T5 same-cycle RD+WR, then aliased address
    step(1'b1, 1'b1, 16'h0020, 16'h2222);
    step(1'b1, 1'b0, 16'h0420, 16'h0);
    chk("t5_old", DataOut, 16'h1111);
    idle(1);
    chk("t5_alias_fwd", DataOut, 16'h2222);
    idle(2);
    step(1'b1, 1'b0, 16'h0420, 16'h0);
    idle(1);
    chk("t5_alias_array", DataOut, 16'h2222);
    idle(2);

    // T6 reset with buffered writes and a read in flight
    step(1'b1, 1'b1, 16'h0050, 16'hDEAD);
    step(1'b1, 1'b1, 16'h0051, 16'hBEAD);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    chk("t6_Idle", Idle, 1'b1);
    chk("t6_Ovf", Ovf, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      chk("t6_no_vld", RdValid, 1'b0);
    end
    step(1'b1, 1'b0, 16'h0050, 16'h0);
    step(1'b1, 1'b0, 16'h0051, 16'h0);
    chk("t6_w50", DataOut, 16'hC050);
    idle(1);
    chk("t6_w51", DataOut, 16'hC051);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
